// File: rtl/bram_pkg.sv
// Shared sizing constants and word type for the 16 Kbit simple dual-port RAM.
package bram_pkg;
    localparam int BRAM16K_DATA_W = 32;
    localparam int BRAM16K_ADDR_W = 9;
    localparam int BRAM16K_DEPTH  = 512;

    typedef logic [BRAM16K_DATA_W-1:0] bram16k_word_t;
endpackage

// File: rtl/bram_16k_array.sv
// Plain storage with one write port and a registered read port; no reset so the
// array maps directly onto a vendor block RAM.
module bram_16k_array
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM16K_DATA_W,
    parameter int ADDR_W = BRAM16K_ADDR_W
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read and write in one process: a same-address read returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bram_16k.sv
// 512 x 32 simple dual-port RAM: inferred array plus async-reset output stage
// and an optional registered read-during-write bypass.
module bram_16k
    import bram_pkg::*;
#(
    parameter int DATA_W  = BRAM16K_DATA_W,
    parameter int ADDR_W  = BRAM16K_ADDR_W,
    parameter int RDW_NEW = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    logic              wr_en;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    assign wr_en = wren & ~reset;

    bram_16k_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wraddress),
        .wr_data (data),
        .rd_addr (rdaddress),
        .rd_data (rd_data)
    );

    // out_valid masks the unreset array output until the first edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            byp_hit   <= 1'b0;
            byp_data  <= '0;
        end else begin
            out_valid <= 1'b1;
            byp_hit   <= (RDW_NEW != 0) && wren && (rdaddress == wraddress);
            byp_data  <= data;
        end
    end

    always_comb begin
        q = '0;
        if (out_valid) begin
            q = byp_hit ? byp_data : rd_data;
        end
    end

endmodule

// File: tb/tb_bram_16k.sv
// Randomized scoreboard bench for bram_16k, covering both read-during-write modes.
module tb_bram_16k;

    logic        clock;
    logic        reset;
    logic [31:0] data;
    logic [8:0]  rdaddress;
    logic [8:0]  wraddress;
    logic        wren;
    logic [31:0] q_old;
    logic [31:0] q_new;

    int n_checks = 0;
    int n_fail   = 0;

    // kind: 0 = no check (unknown contents), 1 = must equal, 2 = must differ
    typedef struct {
        string       name;
        int          kind0;
        logic [31:0] val0;
        int          kind1;
        logic [31:0] val1;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] model_mem [512];
    bit          written   [512];

    bram_16k #(.DATA_W(32), .ADDR_W(9), .RDW_NEW(0)) dut_old (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q_old)
    );

    bram_16k #(.DATA_W(32), .ADDR_W(9), .RDW_NEW(1)) dut_new (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q_new)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input string which, input int kind,
                         input logic [31:0] got, input logic [31:0] want);
        if (kind == 0) return;
        n_checks++;
        if (kind == 1 && got !== want) begin
            n_fail++;
            $display("FAIL %s %s: q=%h required %h", name, which, got, want);
        end else if (kind == 2 && got === want) begin
            n_fail++;
            $display("FAIL %s %s: q=%h required anything but %h", name, which, got, want);
        end
    endtask

    // Drive one cycle of stimulus and record what each variant must show after the edge.
    task automatic step(input bit r, input bit w, input int wa, input logic [31:0] wd,
                        input int ra, input string name);
        exp_t e;
        @(negedge clock);
        reset     = r;
        wren      = w;
        wraddress = 9'(wa);
        data      = wd;
        rdaddress = 9'(ra);
        e.name = name;
        if (r) begin
            e.kind0 = 1; e.val0 = 32'h0;
            e.kind1 = 1; e.val1 = 32'h0;
        end else begin
            if (written[ra])            begin e.kind0 = 1; e.val0 = model_mem[ra]; end
            else if (w && wa == ra)     begin e.kind0 = 2; e.val0 = wd; end
            else                        begin e.kind0 = 0; e.val0 = 32'h0; end
            if (w && wa == ra)          begin e.kind1 = 1; e.val1 = wd; end
            else if (written[ra])       begin e.kind1 = 1; e.val1 = model_mem[ra]; end
            else                        begin e.kind1 = 0; e.val1 = 32'h0; end
            if (w) begin
                model_mem[wa] = wd;
                written[wa]   = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: q is registered, so each expectation is due just after the next edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, "rdw_old", e.kind0, q_old, e.val0);
            check(e.name, "rdw_new", e.kind1, q_new, e.val1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        reset = 1'b0; wren = 1'b0; data = '0; rdaddress = '0; wraddress = '0;
        #2 reset = 1'b1;
        #1;
        check("reset_async_start", "rdw_old", 1, q_old, 32'h0);
        check("reset_async_start", "rdw_new", 1, q_new, 32'h0);
        repeat (3) step(1, 1, 0, 32'h0, 0, "reset_hold");

        step(0, 1, 0, 32'hDEADBEEF, 0, "basic_first_edge");
        step(0, 0, 0, 32'h0, 0, "basic_second_edge");

        step(0, 1, 5, 32'h12345678, 0, "latency_wr5");
        step(0, 1, 6, 32'hCAFEF00D, 5, "latency_wr6");
        step(0, 0, 0, 32'h0, 5, "latency_rd5");
        step(0, 0, 0, 32'h0, 6, "latency_rd6");

        for (int i = 0; i < 512; i++)
            step(0, 1, i, 32'(i) ^ 32'hA5A5A5A5, $urandom_range(0, 511), "fill_write");
        for (int i = 0; i < 512; i++)
            step(0, 0, $urandom_range(0, 511), $urandom, i,
                 (i == 0) ? "range_addr0" : (i == 511) ? "range_addr511" : "range_read");

        step(0, 1, 20, 32'h2, 0, "indep_setup");
        step(0, 1, 10, 32'h1, 20, "indep_rd20");
        step(0, 0, 0, 32'h0, 10, "indep_rd10");

        for (int i = 0; i < 10; i++)
            step(0, 0, 7, 32'hFFFFFFFF, $urandom_range(0, 511), "hold_idle");
        step(0, 0, 7, 32'hFFFFFFFF, 7, "hold_rd7");

        step(0, 1, 0, 32'hDEADBEEF, 3, "rst_setup_wr");
        step(0, 0, 0, 32'h0, 0, "rst_setup_rd");
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("reset_async_mid", "rdw_old", 1, q_old, 32'h0);
        check("reset_async_mid", "rdw_new", 1, q_new, 32'h0);
        step(1, 1, 0, 32'h0, 0, "rst_wr_ignored");
        step(1, 1, 0, 32'h0, 0, "rst_wr_ignored");
        @(negedge clock);
        reset = 1'b0; wren = 1'b0;
        #1;
        check("reset_release_no_edge", "rdw_old", 1, q_old, 32'h0);
        check("reset_release_no_edge", "rdw_new", 1, q_new, 32'h0);
        step(0, 0, 0, 32'h0, 0, "rst_retained");

        for (int i = 0; i < 300; i++)
            step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                 $urandom_range(0, 15), "random_mix");
        step(0, 0, 0, 32'h0, 0, "final_read");

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clock);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
